adc_scan_ctrl: RTL and testbench

//  Parametrised ADC0809-style multi-channel scan controller: drives adc_clock/ale/start/oe/address,

---
 rtl/adc_scan_pkg.sv | 36 +++
 rtl/adc_clk_div.sv | 31 +++
 rtl/adc_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// Shared definitions for the ADC0809-style scan controller: FSM states, address width
// and the round-robin channel picker.
package adc_scan_pkg;

    localparam int unsigned CH_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_READ,
        S_NEXT
    } scan_state_t;

    // First enabled channel at or after ptr, wrapping at n; returns ptr if none enabled.
    function automatic logic [CH_W-1:0] pick_channel(input logic [7:0] mask,
                                                     input logic [CH_W-1:0] ptr,
                                                     input int unsigned n);
        logic [CH_W-1:0] sel;
        logic            found;
        int unsigned     idx;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i < n && !found && mask[idx[2:0]]) begin
                sel   = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Conversion clock divider: adc_clock toggles every CLK_DIV clocks; tick is a one-cycle
// enable coinciding with each rising edge of adc_clock.
module adc_clk_div #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clock,
    input  logic reset,
    output logic adc_clock,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            adc_clock <= 1'b0;
            tick      <= 1'b0;
        end else if (cnt == CW'(CLK_DIV - 1)) begin
            cnt       <= '0;
            adc_clock <= ~adc_clock;
            tick      <= ~adc_clock;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel ADC0809 scan controller with channel mask, EOC timeout and status strobes.
// Optional ADC_ALARM_EN adds a per-channel high-threshold alarm.
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DW          = 8,
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic [DW-1:0]        adc_data,
    input  logic                 eoc,
`ifdef ADC_ALARM_EN
    input  logic [DW-1:0]        alarm_hi,
`endif
    output logic                 adc_clock,
    output logic                 ale,
    output logic                 start,
    output logic                 oe,
    output logic [CH_W-1:0]      address,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [NUM_CH-1:0]    out_valid,
    output logic                 sample_stb,
    output logic [CH_W-1:0]      sample_ch,
    output logic                 timeout_err
`ifdef ADC_ALARM_EN
    ,output logic [NUM_CH-1:0]   alarm
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    scan_state_t     state, next_state;
    logic            tick;
    logic            eoc_meta, eoc_s;
    logic [CH_W-1:0] ch, ptr, pick;
    logic [TW-1:0]   tcnt;
    logic            rd_cnt;
    logic [7:0]      mask8;
    logic            t_exp, do_store, do_timeout;

    adc_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clock     (clock),
        .reset     (reset),
        .adc_clock (adc_clock),
        .tick      (tick)
    );

    always_comb begin
        mask8               = '0;
        mask8[NUM_CH-1:0]   = ch_mask;
        pick                = pick_channel(mask8, ptr, NUM_CH);
        t_exp               = (tcnt == TW'(TIMEOUT_CYC - 1));
    end

    always_comb begin
        next_state = state;
        ale        = 1'b0;
        start      = 1'b0;
        oe         = 1'b0;
        do_store   = 1'b0;
        do_timeout = 1'b0;
        case (state)
            S_IDLE:    if (run && |ch_mask) next_state = S_ADDR;
            S_ADDR: begin
                ale = 1'b1;
                if (tick) next_state = S_START;
            end
            S_START: begin
                ale   = 1'b1;
                start = 1'b1;
                if (tick) next_state = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (t_exp) begin
                    do_timeout = 1'b1;
                    next_state = S_NEXT;
                end else if (!eoc_s) begin
                    next_state = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (t_exp) begin
                    do_timeout = 1'b1;
                    next_state = S_NEXT;
                end else if (eoc_s) begin
                    next_state = S_READ;
                end
            end
            S_READ: begin
                oe = 1'b1;
                // data sampled on the second edge after oe rises
                if (rd_cnt) begin
                    do_store   = 1'b1;
                    next_state = S_NEXT;
                end
            end
            S_NEXT:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            eoc_meta    <= 1'b0;
            eoc_s       <= 1'b0;
            ch          <= '0;
            ptr         <= '0;
            address     <= '0;
            tcnt        <= '0;
            rd_cnt      <= 1'b0;
            out_data    <= '0;
            out_valid   <= '0;
            sample_stb  <= 1'b0;
            sample_ch   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            eoc_meta    <= eoc;
            eoc_s       <= eoc_meta;
            sample_stb  <= do_store;
            timeout_err <= do_timeout;
            rd_cnt      <= (state == S_READ) ? ~rd_cnt : 1'b0;

            if (state == S_IDLE && next_state == S_ADDR) begin
                ch      <= pick;
                address <= pick;
            end

            if (state == S_START)
                tcnt <= '0;
            else if (state == S_WAIT_LO || state == S_WAIT_HI)
                tcnt <= tcnt + 1'b1;

            if (do_store) begin
                out_data[32'(ch)*DW +: DW] <= adc_data;
                out_valid[ch]              <= 1'b1;
            end
            if (do_store || do_timeout)
                sample_ch <= ch;

            if (state == S_NEXT)
                ptr <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
        end
    end

`ifdef ADC_ALARM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            alarm <= '0;
        else if (do_store)
            alarm[ch] <= (adc_data > alarm_hi);
    end
`endif

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: a behavioural ADC answers each conversion and queues
// the expected result; an independent monitor checks every store/timeout the DUT reports.
module tb_adc_scan_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CD = 2;
    localparam int unsigned TO = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            run = 1'b0;
    logic            eoc = 1'b1;
    logic [N-1:0]    ch_mask = '0;
    logic [DW-1:0]   adc_data = '0;
    logic            adc_clock, ale, start, oe, sample_stb, timeout_err;
    logic [2:0]      address, sample_ch;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_valid;
`ifdef ADC_ALARM_EN
    logic [DW-1:0]   alarm_hi = '0;
    logic [N-1:0]    alarm;
`endif

    adc_scan_ctrl #(.NUM_CH(N), .DW(DW), .CLK_DIV(CD), .TIMEOUT_CYC(TO)) dut (
        .clock(clk), .reset(reset), .run(run), .ch_mask(ch_mask), .adc_data(adc_data),
        .eoc(eoc),
`ifdef ADC_ALARM_EN
        .alarm_hi(alarm_hi), .alarm(alarm),
`endif
        .adc_clock(adc_clock), .ale(ale), .start(start), .oe(oe), .address(address),
        .out_data(out_data), .out_valid(out_valid), .sample_stb(sample_stb),
        .sample_ch(sample_ch), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          to;
        int unsigned ch;
        logic [DW-1:0] data;
        int unsigned t0;
    } exp_t;

    exp_t          q[$];
    exp_t          me, ae;
    logic [DW-1:0] exp_data [N];
    logic [N-1:0]  exp_valid = '0;
    int unsigned   n_checks = 0, n_fail = 0, cyc = 0;
    int unsigned   n_starts = 0, n_stores = 0, n_to = 0, ptr = 0;
    int unsigned   data_mode = 0;
    logic [DW-1:0] fixed_val = '0;
    bit            hang = 0, in_wait_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Next enabled channel at or after p, round robin over N channels.
    function automatic int unsigned next_ch(input logic [N-1:0] m, input int unsigned p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return p;
    endfunction

    // Behavioural ADC: answers each start pulse with an EOC low/high handshake.
    initial begin
        forever begin
            @(negedge clk iff (start && !reset));
            n_starts++;
            ae.ch = next_ch(ch_mask, ptr);
            chk("address", 64'(address), 64'(ae.ch));
            chk("ale_during_start", 64'(ale), 64'd1);
            ptr = (ae.ch + 1) % N;
            @(negedge clk iff !start);
            ae.t0 = cyc;
            if (hang) begin
                ae.to = 1; ae.data = '0;
                q.push_back(ae);
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                eoc = 1'b0;
                repeat (4) @(negedge clk);
                in_wait_hi = 1;
                repeat ($urandom_range(1, 26)) @(negedge clk);
                in_wait_hi = 0;
                case (data_mode)
                    1:       ae.data = DW'(8'h10 + ae.ch);
                    2:       ae.data = fixed_val;
                    default: ae.data = DW'($urandom);
                endcase
                ae.to = 0;
                adc_data = ae.data;
                eoc = 1'b1;
                q.push_back(ae);
            end
        end
    end

    // Monitor: every store or timeout must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (sample_stb || timeout_err)) begin
            if (q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_event: got stb=%0b to=%0b required none", sample_stb, timeout_err);
            end else begin
                me = q.pop_front();
                chk("event_is_timeout", 64'(timeout_err), 64'(me.to));
                chk("event_is_store", 64'(sample_stb), 64'(!me.to));
                chk("sample_ch", 64'(sample_ch), 64'(me.ch));
                if (me.to) begin
                    n_to++;
                    chk("timeout_latency_in_62_66", 64'((cyc - me.t0) >= 62 && (cyc - me.t0) <= 66), 64'd1);
                end else begin
                    n_stores++;
                    exp_data[me.ch] = me.data;
                    exp_valid[me.ch] = 1'b1;
                    chk("out_data_slot", 64'(out_data[me.ch*DW +: DW]), 64'(me.data));
                    chk("out_valid", 64'(out_valid), 64'(exp_valid));
                end
            end
        end
    end

    // sel: 0 oe high, 1 ADC in WAIT_HI window, 2 timeouts >= tgt, 3 stores >= tgt
    task automatic wait_until(input int sel, input int unsigned tgt, input string name);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if ((sel == 0 && oe) || (sel == 1 && in_wait_hi) ||
                (sel == 2 && n_to >= tgt) || (sel == 3 && n_stores >= tgt)) return;
        end
        n_checks++; n_fail++;
        $display("FAIL wait_%s: got no event required event within 5000 cycles", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl_outs"}, 64'({adc_clock, ale, start, oe, address, sample_stb, sample_ch, timeout_err}), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        #1;
        check_reset_outputs(tag);
        q.delete();
        exp_valid = '0;
        ptr = 0;
        foreach (exp_data[i]) exp_data[i] = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic settle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    int unsigned s0, st0;

    initial begin
        foreach (exp_data[i]) exp_data[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // reset while a conversion is being read out
        ch_mask = 4'b1111; run = 1'b1;
        wait_until(3, 1, "first_store");
        wait_until(0, 0, "oe");
        do_reset("rst_mid_read");

        // sparse mask: channels 0 and 2 only
        ch_mask = 4'b0101; run = 1'b1;
        wait_until(3, n_stores + 4, "mask0101");
        run = 1'b0; settle(200);
        chk("valid_mask0101", 64'(out_valid), 64'h5);
        do_reset("rst2");

        // full mask, data 8'h10+ch
        data_mode = 1; ch_mask = 4'b1111; run = 1'b1;
        wait_until(3, n_stores + 8, "full_scan");
        run = 1'b0; settle(200);
        chk("full_scan_data", 64'(out_data), 64'h13121110);
        chk("full_scan_valid", 64'(out_valid), 64'hF);

        // EOC never falls: one timeout, then the scan continues with the next channel
        data_mode = 0; hang = 1; run = 1'b1;
        s0 = n_to;
        wait_until(2, s0 + 1, "timeout");
        hang = 0;
        wait_until(3, n_stores + 3, "after_timeout");
        run = 1'b0; settle(200);

        // run dropped during WAIT_HI: current channel completes, nothing else starts
        run = 1'b1;
        wait_until(1, 0, "wait_hi");
        run = 1'b0;
        s0 = n_starts; st0 = n_stores;
        settle(300);
        chk("rundrop_stores", 64'(n_stores), 64'(st0 + 1));
        chk("rundrop_no_start", 64'(n_starts), 64'(s0));
        chk("rundrop_strobes", 64'({ale, start, oe}), 64'd0);

        // empty mask with run high stays idle
        ch_mask = '0; run = 1'b1; s0 = n_starts;
        settle(200);
        chk("mask0_no_start", 64'(n_starts), 64'(s0));
        chk("mask0_strobes", 64'({ale, start, oe}), 64'd0);
        run = 1'b0;

        // randomized masks and data
        for (int it = 0; it < 30; it++) begin
            ch_mask = N'($urandom_range(1, 15));
            run = 1'b1;
            wait_until(3, n_stores + $urandom_range(1, 4), "random");
            run = 1'b0;
            settle(150);
        end

`ifdef ADC_ALARM_EN
        alarm_hi = 8'h80; data_mode = 2; ch_mask = 4'b0010;
        fixed_val = 8'h81; run = 1'b1;
        wait_until(3, n_stores + 1, "alarm_hi");
        run = 1'b0; settle(150);
        chk("alarm_set", 64'(alarm[1]), 64'd1);
        fixed_val = 8'h80; run = 1'b1;
        wait_until(3, n_stores + 1, "alarm_eq");
        run = 1'b0; settle(150);
        chk("alarm_clear", 64'(alarm[1]), 64'd0);
`endif

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
